// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Bundle between the fetch unit and its surroundings: pipeline
//               control, branch/exception redirect, instruction ROM bus and
//               the IF/ID register outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        fault_o;

  // Fetch unit side: drives the ROM bus and the IF/ID register.
  modport master (
    input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    input  rom_data_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fault_o
  );

  // Environment side: control, ROM and decode stage.
  modport slave (
    output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    output rom_data_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fault_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch front end. Generates the PC, drives the
//               combinational instruction ROM, and fills the IF/ID register.
//               Handles stalls, bubbles, delayed branches, exception flushes
//               and misaligned/out-of-range fetch faults.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          INST_MEM_NUM_LOG2 = 17
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FAULT = 2'd2;

  // First byte-address bit that must be zero for an in-range fetch.
  localparam int c_ADDR_MSB = INST_MEM_NUM_LOG2 + 2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_cand_pc;
  logic [31:0] w_next_pc;
  logic        r_rom_ce;
  logic        r_fault;
  logic        w_rom_ce_d;
  logic        w_fault_d;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_bad;
  logic        w_unused_stall;

  // Upper stall bits belong to later stages.
  assign w_unused_stall = ^bus.stall[5:3];

  // Candidate next PC by redirect priority; stalls and branches only matter in RUN.
  always_comb begin
    w_cand_pc = r_pc;
    case (r_state)
      c_RUN: begin
        if (bus.flush)              w_cand_pc = bus.new_pc;
        else if (bus.stall[0])      w_cand_pc = r_pc;
        else if (bus.branch_flag_i) w_cand_pc = bus.branch_target_address_i;
        else                        w_cand_pc = r_pc + 32'd4;
      end
      c_FAULT: begin
        if (bus.flush) w_cand_pc = bus.new_pc;
      end
      default: w_cand_pc = r_pc;
    endcase
  end

  assign w_misaligned = |w_cand_pc[1:0];

  generate
    if (c_ADDR_MSB < 32) begin : g_range_check
      assign w_out_of_range = |w_cand_pc[31:c_ADDR_MSB];
    end else begin : g_full_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_bad = w_misaligned | w_out_of_range;

  // Next-state and next-PC selection; a bad candidate is still loaded so it can be reported.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    case (r_state)
      c_IDLE: begin
        w_next_state = c_RUN;
      end
      c_RUN: begin
        w_next_pc    = w_cand_pc;
        w_next_state = w_bad ? c_FAULT : c_RUN;
      end
      c_FAULT: begin
        if (bus.flush) begin
          w_next_pc    = w_cand_pc;
          w_next_state = w_bad ? c_FAULT : c_RUN;
        end
      end
      default: begin
        w_next_state = c_IDLE;
        w_next_pc    = RESET_PC;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    w_rom_ce_d = (w_next_state == c_RUN);
    w_fault_d  = (w_next_state == c_FAULT);
  end

  // State, PC and registered ROM enable / fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_pc     <= RESET_PC;
      r_rom_ce <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_next_pc;
      r_rom_ce <= w_rom_ce_d;
      r_fault  <= w_fault_d;
    end
  end

  // IF/ID register: flush beats stall, bubble when IF stalls but ID moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_pc    <= 32'd0;
      r_id_inst  <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (bus.flush || (bus.stall[1] && !bus.stall[2])) begin
      r_id_pc    <= 32'd0;
      r_id_inst  <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (bus.stall[1]) begin
      r_id_pc    <= r_id_pc;
      r_id_inst  <= r_id_inst;
      r_id_valid <= r_id_valid;
    end else if (r_rom_ce) begin
      r_id_pc    <= r_pc;
      r_id_inst  <= bus.rom_data_i;
      r_id_valid <= 1'b1;
    end else begin
      r_id_pc    <= 32'd0;
      r_id_inst  <= 32'd0;
      r_id_valid <= 1'b0;
    end
  end

  assign bus.rom_ce_o   = r_rom_ce;
  assign bus.rom_addr_o = r_pc;
  assign bus.fault_o    = r_fault;
  assign bus.id_pc_o    = r_id_pc;
  assign bus.id_inst_o  = r_id_inst;
  assign bus.id_valid_o = r_id_valid;

endmodule
`default_nettype wire
